// File: rtl/scan_display_ctrl.sv
// Multiplexed segment-display scanner: steps through enabled digits one slot at a time,
// with an anti-ghost blank at the start of each slot and PWM brightness inside it.

module scan_digit_drv #(
    parameter int SEG_W = 7,
    parameter int IDX_W = 3,
    parameter int IDX   = 0
) (
    input  logic             lit,
    input  logic [IDX_W-1:0] scan_idx,
    input  logic [SEG_W-1:0] pattern,
    output logic             sel,
    output logic [SEG_W-1:0] seg_term
);
    assign sel      = lit && (scan_idx == IDX_W'(IDX));
    assign seg_term = sel ? pattern : '0;
endmodule

module scan_display_ctrl #(
    parameter int NUM_DIGITS    = 8,
    parameter int SEG_W         = 7,
    parameter int DIV_W         = 16,
    parameter int BLANK_CYC     = 4,
    parameter int ANODE_ACT_LOW = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_DIGITS*SEG_W-1:0] disp_bus,
    input  logic [NUM_DIGITS-1:0]       digit_en,
    input  logic [DIV_W-1:0]            scan_div,
    input  logic [3:0]                  bright,
    output logic [SEG_W-1:0]            segment,
    output logic [NUM_DIGITS-1:0]       anode_ctrl,
    output logic                        frame_start
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ANODE_ACT_LOW != 0) ? '1 : '0;

    logic [DIV_W-1:0]                      div_cnt;
    logic [3:0]                            pwm_cnt;
    logic [IDX_W-1:0]                      scan_idx;
    logic [IDX_W-1:0]                      next_idx;
    logic [IDX_W:0]                        cand;
    logic                                  slot_end;
    logic                                  any_en;
    logic                                  lit;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]      digits;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]      seg_terms;
    logic [NUM_DIGITS-1:0]                 sel;
    logic [SEG_W-1:0]                      seg_mux;

    assign digits   = disp_bus;
    assign any_en   = |digit_en;
    // >= rather than == so a shrinking scan_div cannot strand the counter past the end
    assign slot_end = (div_cnt >= scan_div);
    assign lit      = digit_en[scan_idx] && (div_cnt >= DIV_W'(BLANK_CYC)) && (pwm_cnt <= bright);

    // Search upward from scan_idx+1, wrapping; iterating from the far end lets the nearest hit win.
    // k = NUM_DIGITS lands back on scan_idx itself, covering the single-digit case.
    always_comb begin
        next_idx = scan_idx;
        cand     = '0;
        for (int k = NUM_DIGITS; k >= 1; k--) begin
            cand = {1'b0, scan_idx} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_DIGITS))
                cand = cand - (IDX_W+1)'(NUM_DIGITS);
            if (digit_en[cand[IDX_W-1:0]])
                next_idx = cand[IDX_W-1:0];
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        scan_digit_drv #(.SEG_W(SEG_W), .IDX_W(IDX_W), .IDX(i)) u_drv (
            .lit      (lit),
            .scan_idx (scan_idx),
            .pattern  (digits[i]),
            .sel      (sel[i]),
            .seg_term (seg_terms[i])
        );
    end

    always_comb begin
        seg_mux = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            seg_mux = seg_mux | seg_terms[i];
    end

    // Segment and anode leave from the same register stage so they can never skew.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            pwm_cnt     <= '0;
            scan_idx    <= '0;
            segment     <= '0;
            anode_ctrl  <= ANODE_OFF;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= slot_end ? '0 : div_cnt + 1'b1;
            pwm_cnt     <= pwm_cnt + 4'd1;
            if (slot_end && any_en)
                scan_idx <= next_idx;
            frame_start <= slot_end && any_en && (next_idx <= scan_idx);
            segment     <= seg_mux;
            anode_ctrl  <= sel ^ ANODE_OFF;
        end
    end
endmodule
